// File: rtl/mspeckey_dec_iter_if.sv
// Ready/valid bus for the iterative mini-SPECK decryptor.
// master: the driving side (sends ciphertext, accepts plaintext)
// slave : the decryptor itself
//   in_valid/in_ready/in_data    ciphertext word {Th, Tl}
//   out_valid/out_ready/out_data plaintext word {X, Y}
//   busy                         decryptor is in RUN or DONE
interface mspeckey_dec_iter_if;
  localparam int unsigned DATA_W = 16;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              busy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/mspeckey_dec_iter.sv
// Iterative decryptor for the 16-bit mini-SPECK keyless round.
// Undoes ROUNDS chained forward rounds, one inverse round per clock.
// Ports:
//   clk   rising-edge clock
//   rst_n synchronous active-low reset
//   bus   mspeckey_dec_iter_if.slave (ready/valid in and out, busy)
module mspeckey_dec_iter #(
  parameter int unsigned ROUNDS = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  mspeckey_dec_iter_if.slave  bus
);

  localparam int unsigned HALF_W = 8;
  localparam int unsigned DATA_W = 2 * HALF_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   s_q, s_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                in_ready_q, out_valid_q, busy_q;

  // One inverse round: {Th,Tl} -> {X,Y}.
  function automatic logic [DATA_W-1:0] inv_round(input logic [DATA_W-1:0] s);
    logic [HALF_W-1:0] th, tl, x_mix, y_new, diff;
    th    = s[DATA_W-1:HALF_W];
    tl    = s[HALF_W-1:0];
    x_mix = tl ^ th;
    y_new = {x_mix[1:0], x_mix[7:2]};
    diff  = th - y_new;
    return {diff[0], diff[7:1], y_new};
  endfunction

  // Next-state and datapath selection.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          s_d     = bus.in_data;
          cnt_d   = CNT_W'(ROUNDS);
          state_d = RUN;
        end
      end
      RUN: begin
        s_d   = inv_round(s_q);
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; status flags are precomputed from the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      s_q         <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      s_q         <= s_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= (state_d == IDLE);
      out_valid_q <= (state_d == DONE);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = s_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mspeckey_dec_iter.sv
// Directed and round-trip bench for mspeckey_dec_iter with ROUNDS = 1, 2 and 8.
module tb_mspeckey_dec_iter;

  localparam int unsigned N_RT = 1000;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mspeckey_dec_iter_if bus1 ();
  mspeckey_dec_iter_if bus2 ();
  mspeckey_dec_iter_if bus8 ();

  mspeckey_dec_iter #(.ROUNDS(1), .CNT_W(8)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  mspeckey_dec_iter #(.ROUNDS(2), .CNT_W(8)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));
  mspeckey_dec_iter #(.ROUNDS(8), .CNT_W(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Forward round used to build ciphertexts.
  function automatic logic [15:0] fwd1(input logic [15:0] p);
    logic [7:0] x, y, th, tl;
    x  = p[15:8];
    y  = p[7:0];
    th = {x[6:0], x[7]} + y;
    tl = {y[5:0], y[7:6]} ^ th;
    return {th, tl};
  endfunction

  function automatic logic [15:0] fwd8(input logic [15:0] p);
    logic [15:0] v;
    v = p;
    for (int i = 0; i < 8; i++) v = fwd1(v);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus8.in_ready !== 1'b1 || bus8.out_valid !== 1'b0 || bus8.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags8: got rdy=%b vld=%b busy=%b expected 1 0 0",
               bus8.in_ready, bus8.out_valid, bus8.busy);
    end
    checks++;
    if (bus8.out_data !== 16'h0000) begin
      errors++;
      $display("FAIL reset_data8: got %h expected 0000", bus8.out_data);
    end
    checks++;
    if (bus1.in_ready !== 1'b1 || bus1.out_valid !== 1'b0 || bus1.out_data !== 16'h0000) begin
      errors++;
      $display("FAIL reset_r1: got rdy=%b vld=%b data=%h expected 1 0 0000",
               bus1.in_ready, bus1.out_valid, bus1.out_data);
    end
  endtask

  task automatic test_r1();
    logic [15:0] ct [3];
    logic [15:0] pt [3];
    ct[0] = 16'h0202; pt[0] = 16'h0100;
    ct[1] = 16'h0206; pt[1] = 16'h8001;
    ct[2] = 16'h0004; pt[2] = 16'hFF01;
    for (int i = 0; i < 3; i++) begin
      bus1.in_valid = 1'b1;
      bus1.in_data  = ct[i];
      tick();
      bus1.in_valid = 1'b0;
      checks++;
      if (bus1.out_valid !== 1'b0 || bus1.busy !== 1'b1 || bus1.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL r1_run[%0d]: got vld=%b busy=%b rdy=%b expected 0 1 0",
                 i, bus1.out_valid, bus1.busy, bus1.in_ready);
      end
      tick();
      checks++;
      if (bus1.out_valid !== 1'b1 || bus1.out_data !== pt[i]) begin
        errors++;
        $display("FAIL r1_data[%0d]: got vld=%b data=%h expected 1 %h",
                 i, bus1.out_valid, bus1.out_data, pt[i]);
      end
      bus1.out_ready = 1'b1;
      tick();
      bus1.out_ready = 1'b0;
      checks++;
      if (bus1.in_ready !== 1'b1 || bus1.out_valid !== 1'b0 || bus1.busy !== 1'b0) begin
        errors++;
        $display("FAIL r1_idle[%0d]: got rdy=%b vld=%b busy=%b expected 1 0 0",
                 i, bus1.in_ready, bus1.out_valid, bus1.busy);
      end
    end
  endtask

  task automatic test_r2_latency();
    bus2.in_valid = 1'b1;
    bus2.in_data  = 16'h060E;
    tick();
    bus2.in_valid = 1'b0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (bus2.out_valid !== 1'b0 || bus2.in_ready !== 1'b0 || bus2.busy !== 1'b1) begin
        errors++;
        $display("FAIL r2_window[%0d]: got vld=%b rdy=%b busy=%b expected 0 0 1",
                 k, bus2.out_valid, bus2.in_ready, bus2.busy);
      end
      if (k == 0) tick();
      else tick();
    end
    checks++;
    if (bus2.out_valid !== 1'b1 || bus2.in_ready !== 1'b0 || bus2.busy !== 1'b1
        || bus2.out_data !== 16'h0100) begin
      errors++;
      $display("FAIL r2_done: got vld=%b rdy=%b busy=%b data=%h expected 1 0 1 0100",
               bus2.out_valid, bus2.in_ready, bus2.busy, bus2.out_data);
    end
    bus2.out_ready = 1'b1;
    tick();
    bus2.out_ready = 1'b0;
    checks++;
    if (bus2.in_ready !== 1'b1 || bus2.busy !== 1'b0) begin
      errors++;
      $display("FAIL r2_idle: got rdy=%b busy=%b expected 1 0", bus2.in_ready, bus2.busy);
    end
  endtask

  task automatic test_backpressure();
    bus8.out_ready = 1'b0;
    bus8.in_valid  = 1'b1;
    bus8.in_data   = fwd8(16'h1234);
    tick();
    bus8.in_valid  = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    checks++;
    if (bus8.out_valid !== 1'b1 || bus8.out_data !== 16'h1234) begin
      errors++;
      $display("FAIL bp_first: got vld=%b data=%h expected 1 1234", bus8.out_valid, bus8.out_data);
    end
    bus8.in_valid = 1'b1;
    bus8.in_data  = fwd8(16'hBEEF);
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (bus8.out_valid !== 1'b1 || bus8.out_data !== 16'h1234 || bus8.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got vld=%b data=%h rdy=%b expected 1 1234 0",
                 k, bus8.out_valid, bus8.out_data, bus8.in_ready);
      end
    end
    // Output handshake with in_valid still high: only the output side completes.
    bus8.out_ready = 1'b1;
    tick();
    bus8.out_ready = 1'b0;
    checks++;
    if (bus8.out_valid !== 1'b0 || bus8.in_ready !== 1'b1 || bus8.busy !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: got vld=%b rdy=%b busy=%b expected 0 1 0",
               bus8.out_valid, bus8.in_ready, bus8.busy);
    end
    tick();
    bus8.in_valid = 1'b0;
    checks++;
    if (bus8.busy !== 1'b1 || bus8.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_accept_next: got busy=%b rdy=%b expected 1 0", bus8.busy, bus8.in_ready);
    end
    for (int k = 0; k < 8; k++) tick();
    checks++;
    if (bus8.out_valid !== 1'b1 || bus8.out_data !== 16'hBEEF) begin
      errors++;
      $display("FAIL bp_second: got vld=%b data=%h expected 1 beef", bus8.out_valid, bus8.out_data);
    end
    bus8.out_ready = 1'b1;
    tick();
    bus8.out_ready = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [15:0] pt [N_RT];
    logic [15:0] ct [N_RT];
    int fi, ri, last_cyc, cyc;
    logic accepting;
    for (int i = 0; i < int'(N_RT); i++) begin
      pt[i] = 16'($urandom);
      ct[i] = fwd8(pt[i]);
    end
    fi = 0; ri = 0; last_cyc = 0; cyc = 0;
    bus8.out_ready = 1'b1;
    bus8.in_valid  = 1'b1;
    bus8.in_data   = ct[0];
    while (cyc < 12000 && ri < int'(N_RT)) begin
      accepting = bus8.in_ready && bus8.in_valid;
      tick();
      cyc++;
      if (accepting) begin
        fi++;
        bus8.in_valid = (fi < int'(N_RT));
        bus8.in_data  = (fi < int'(N_RT)) ? ct[fi] : 16'h0000;
      end
      if (bus8.out_valid === 1'b1) begin
        checks++;
        if (bus8.out_data !== pt[ri]) begin
          errors++;
          $display("FAIL rt_data[%0d]: got %h expected %h", ri, bus8.out_data, pt[ri]);
        end
        if (ri > 0) begin
          checks++;
          if (cyc - last_cyc != 10) begin
            errors++;
            $display("FAIL rt_spacing[%0d]: got %0d cycles expected 10", ri, cyc - last_cyc);
          end
        end
        last_cyc = cyc;
        ri++;
      end
    end
    checks++;
    if (ri != int'(N_RT)) begin
      errors++;
      $display("FAIL rt_count: got %0d results expected %0d", ri, N_RT);
    end
    bus8.in_valid  = 1'b0;
    bus8.out_ready = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    bus8.in_valid = 1'b1;
    bus8.in_data  = fwd8(16'h1357);
    tick();
    bus8.in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if (bus8.out_valid !== 1'b0 || bus8.out_data !== 16'h0000 || bus8.busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got vld=%b data=%h busy=%b expected 0 0000 0",
               bus8.out_valid, bus8.out_data, bus8.busy);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus8.in_ready !== 1'b1 || bus8.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_release: got rdy=%b vld=%b expected 1 0", bus8.in_ready, bus8.out_valid);
    end
    bus8.in_valid = 1'b1;
    bus8.in_data  = fwd8(16'hA5C3);
    tick();
    bus8.in_valid = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    checks++;
    if (bus8.out_valid !== 1'b1 || bus8.out_data !== 16'hA5C3) begin
      errors++;
      $display("FAIL mid_fresh: got vld=%b data=%h expected 1 a5c3", bus8.out_valid, bus8.out_data);
    end
    bus8.out_ready = 1'b1;
    tick();
    bus8.out_ready = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.out_ready = 1'b0;
    bus2.in_valid = 1'b0; bus2.in_data = '0; bus2.out_ready = 1'b0;
    bus8.in_valid = 1'b0; bus8.in_data = '0; bus8.out_ready = 1'b0;
    test_reset();
    test_r1();
    test_r2_latency();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

endmodule
